// File: rtl/alu_seq.sv
// Registered, handshaked ALU: single-cycle logic/arith ops plus iterative
// shift-add multiply and one-bit-per-cycle logical shifts. One op in flight.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] INPUT_A,
  input  logic [WIDTH-1:0] INPUT_B,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT,
  output logic             ZERO,
  output logic             CARRY
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
  localparam logic [2:0] OP_SHR  = 3'b110;
  localparam logic [2:0] OP_AND  = 3'b111;

  // WIDTH always fits in WIDTH bits (WIDTH >= 2) and in SHW bits.
  localparam logic [WIDTH-1:0] W_B = WIDTH'(WIDTH);
  localparam logic [SHW-1:0]   W_S = SHW'(WIDTH);

  state_t             r_state;
  logic [2:0]         r_op;
  logic [WIDTH-1:0]   r_a, r_b;
  logic [2*WIDTH-1:0] r_acc, r_mc;
  logic [SHW-1:0]     r_cnt;
  logic               r_in_ready, r_out_valid, r_zero, r_carry;
  logic [WIDTH-1:0]   r_out;

  logic [WIDTH:0]     w_sum, w_dif;
  logic [SHW-1:0]     w_s;
  logic               w_go_busy, w_last;
  logic [WIDTH-1:0]   w_res, w_fin_res, w_shl, w_shr;
  logic               w_cy, w_fin_cy;
  logic [2*WIDTH-1:0] w_acc_nxt;

  assign IN_READY  = r_in_ready;
  assign OUT_VALID = r_out_valid;
  assign OUT       = r_out;
  assign ZERO      = r_zero;
  assign CARRY     = r_carry;

  assign w_sum     = {1'b0, INPUT_A} + {1'b0, INPUT_B};
  assign w_dif     = {1'b0, INPUT_A} - {1'b0, INPUT_B};
  // Whole B is compared, so huge counts saturate instead of wrapping.
  assign w_s       = (INPUT_B >= W_B) ? W_S : INPUT_B[SHW-1:0];
  assign w_acc_nxt = r_acc + (r_b[0] ? r_mc : '0);
  assign w_shl     = {r_a[WIDTH-2:0], 1'b0};
  assign w_shr     = {1'b0, r_a[WIDTH-1:1]};
  assign w_last    = (r_cnt == SHW'(1));

  // Result of ops that finish on the accept edge (incl. zero-count shifts).
  always_comb begin
    w_res     = INPUT_A;
    w_cy      = 1'b0;
    w_go_busy = 1'b0;
    case (OP)
      OP_PASS: w_res = INPUT_A;
      OP_SUB:  begin w_res = w_dif[WIDTH-1:0]; w_cy = w_dif[WIDTH]; end
      OP_MUL:  w_go_busy = 1'b1;
      OP_XOR:  w_res = INPUT_A ^ INPUT_B;
      OP_ADD:  begin w_res = w_sum[WIDTH-1:0]; w_cy = w_sum[WIDTH]; end
      OP_SHL,
      OP_SHR:  w_go_busy = (w_s != '0);
      OP_AND:  w_res = INPUT_A & INPUT_B;
      default: w_res = INPUT_A;
    endcase
  end

  always_comb begin
    w_fin_res = w_acc_nxt[WIDTH-1:0];
    w_fin_cy  = |w_acc_nxt[2*WIDTH-1:WIDTH];
    if (r_op == OP_SHL) begin
      w_fin_res = w_shl;
      w_fin_cy  = r_a[WIDTH-1];
    end else if (r_op == OP_SHR) begin
      w_fin_res = w_shr;
      w_fin_cy  = r_a[0];
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_mc        <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (IN_VALID) begin
          r_op       <= OP;
          r_a        <= INPUT_A;
          r_b        <= INPUT_B;
          r_acc      <= '0;
          r_mc       <= {{WIDTH{1'b0}}, INPUT_A};
          r_cnt      <= (OP == OP_MUL) ? W_S : w_s;
          r_in_ready <= 1'b0;
          if (w_go_busy) begin
            r_state <= S_BUSY;
          end else begin
            r_out       <= w_res;
            r_zero      <= (w_res == '0);
            r_carry     <= w_cy;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt - SHW'(1);
          case (r_op)
            OP_MUL: begin
              r_acc <= w_acc_nxt;
              r_mc  <= r_mc << 1;
              r_b   <= r_b >> 1;
            end
            OP_SHL:  r_a <= w_shl;
            default: r_a <= w_shr;
          endcase
          if (w_last) begin
            r_out       <= w_fin_res;
            r_zero      <= (w_fin_res == '0);
            r_carry     <= w_fin_cy;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: if (OUT_READY) begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=8 and WIDTH=16: the driver queues the
// expected result and latency on accept; per-DUT monitors check on OUT_VALID.
module tb_alu_seq;

  typedef struct packed {
    logic [15:0] out;
    logic        z;
    logic        c;
    logic [31:0] lat;
    logic [31:0] acc;
  } exp_t;

  logic        CLK, RESET_N;
  logic        iv8, ir8, ov8, ordy8, z8, c8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, out8;
  logic        iv16, ir16, ov16, ordy16, z16, c16;
  logic [2:0]  op16;
  logic [15:0] a16, b16, out16;

  int   n_vec = 0, n_err = 0;
  int   cyc = 0;
  exp_t q8[$], q16[$];
  exp_t e8, e16;
  logic pv8 = 1'b0, pv16 = 1'b0;

  alu_seq #(.WIDTH(8)) dut8 (
    .CLK(CLK), .RESET_N(RESET_N), .IN_VALID(iv8), .IN_READY(ir8), .OP(op8),
    .INPUT_A(a8), .INPUT_B(b8), .OUT_VALID(ov8), .OUT_READY(ordy8),
    .OUT(out8), .ZERO(z8), .CARRY(c8));

  alu_seq #(.WIDTH(16)) dut16 (
    .CLK(CLK), .RESET_N(RESET_N), .IN_VALID(iv16), .IN_READY(ir16), .OP(op16),
    .INPUT_A(a16), .INPUT_B(b16), .OUT_VALID(ov16), .OUT_READY(ordy16),
    .OUT(out16), .ZERO(z16), .CARRY(c16));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic wait_ready(input bit w16);
    int t = 0;
    while (!(w16 ? ir16 : ir8) && t < 100) begin
      @(posedge CLK); #1; t++;
    end
    if (t >= 100) begin
      n_vec++; n_err++;
      $display("FAIL in_ready_timeout: got 0, expected 1 (w16=%0d)", w16);
    end
  endtask

  // acc = index of the cycle whose closing edge accepted the request, so a
  // result visible right after that edge measures as latency 1.
  task automatic issue(input bit w16, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] eo, input bit ez,
                       input bit ec, input int lat, input bit push);
    exp_t e;
    wait_ready(w16);
    if (w16) begin iv16 = 1'b1; op16 = op; a16 = a; b16 = b; end
    else     begin iv8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0]; end
    @(posedge CLK); #1;
    iv8 = 1'b0; iv16 = 1'b0;
    e.out = eo; e.z = ez; e.c = ec; e.lat = lat; e.acc = cyc - 1;
    if (push) begin
      if (w16) q16.push_back(e); else q8.push_back(e);
    end
  endtask

  always @(negedge CLK) begin
    if (ov8) begin
      if (q8.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL dut8_unexpected_valid: got out=%0h, expected no result", out8);
      end else begin
        e8 = q8[0];
        if (!pv8) chk("dut8_latency", cyc - e8.acc, e8.lat);
        chk("dut8_out", {24'b0, out8}, {16'b0, e8.out});
        chk("dut8_zero", {31'b0, z8}, {31'b0, e8.z});
        chk("dut8_carry", {31'b0, c8}, {31'b0, e8.c});
        if (ordy8) void'(q8.pop_front());
      end
    end
    pv8 = ov8;
  end

  always @(negedge CLK) begin
    if (ov16) begin
      if (q16.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL dut16_unexpected_valid: got out=%0h, expected no result", out16);
      end else begin
        e16 = q16[0];
        if (!pv16) chk("dut16_latency", cyc - e16.acc, e16.lat);
        chk("dut16_out", {16'b0, out16}, {16'b0, e16.out});
        chk("dut16_zero", {31'b0, z16}, {31'b0, e16.z});
        chk("dut16_carry", {31'b0, c16}, {31'b0, e16.c});
        if (ordy16) void'(q16.pop_front());
      end
    end
    pv16 = ov16;
  end

  initial begin
    RESET_N = 1'b0;
    iv8 = 1'b0; op8 = '0; a8 = '0; b8 = '0; ordy8 = 1'b1;
    iv16 = 1'b0; op16 = '0; a16 = '0; b16 = '0; ordy16 = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rst_in_ready", {31'b0, ir8}, 32'd1);
    chk("rst_out_valid", {31'b0, ov8}, 32'd0);
    chk("rst_out", {24'b0, out8}, 32'd0);
    chk("rst_zero_carry", {30'b0, z8, c8}, 32'd0);
    @(posedge CLK); #1;
    RESET_N = 1'b1;

    // add with carry-out, then IN_READY back the cycle after the handshake
    issue(0, 3'b100, 16'hF0, 16'h20, 16'h10, 0, 1, 1, 1);
    @(negedge CLK);
    chk("t1_valid", {31'b0, ov8}, 32'd1);
    chk("t1_busy_in_ready", {31'b0, ir8}, 32'd0);
    @(negedge CLK);
    chk("t1_in_ready_back", {31'b0, ir8}, 32'd1);

    issue(0, 3'b001, 16'h05, 16'h05, 16'h00, 1, 0, 1, 1);
    issue(0, 3'b001, 16'h03, 16'h05, 16'hFE, 0, 1, 1, 1);
    issue(0, 3'b101, 16'h81, 16'd3,   16'h08, 0, 0, 4, 1);
    issue(0, 3'b110, 16'h81, 16'd0,   16'h81, 0, 0, 1, 1);
    issue(0, 3'b110, 16'hFF, 16'd200, 16'h00, 1, 1, 9, 1);
    issue(0, 3'b101, 16'h81, 16'd8,   16'h00, 1, 1, 9, 1);
    issue(0, 3'b110, 16'h02, 16'd2,   16'h00, 1, 1, 3, 1);
    issue(0, 3'b010, 16'h10, 16'h11,  16'h10, 0, 1, 9, 1);
    issue(0, 3'b010, 16'h07, 16'h09,  16'h3F, 0, 0, 9, 1);
    issue(0, 3'b000, 16'h00, 16'h5A,  16'h00, 1, 0, 1, 1);
    issue(0, 3'b111, 16'hF0, 16'h3C,  16'h30, 0, 0, 1, 1);

    // backpressure: result frozen, extra requests ignored
    wait_ready(0);
    ordy8 = 1'b0;
    issue(0, 3'b011, 16'hAA, 16'hFF, 16'h55, 0, 0, 1, 1);
    iv8 = 1'b1; op8 = 3'b100; a8 = 8'h01; b8 = 8'h01;
    repeat (5) begin
      @(negedge CLK);
      chk("bp_in_ready", {31'b0, ir8}, 32'd0);
      chk("bp_out_valid", {31'b0, ov8}, 32'd1);
      @(posedge CLK); #1;
    end
    iv8 = 1'b0;
    ordy8 = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk("bp_idle_valid", {31'b0, ov8}, 32'd0);
    chk("bp_idle_ready", {31'b0, ir8}, 32'd1);

    // async reset during the 4th BUSY cycle of a multiply
    issue(0, 3'b010, 16'h03, 16'h05, 16'h0F, 0, 0, 9, 0);
    repeat (3) @(posedge CLK);
    #2 RESET_N = 1'b0;
    #1;
    chk("mid_rst_out", {24'b0, out8}, 32'd0);
    chk("mid_rst_valid", {31'b0, ov8}, 32'd0);
    chk("mid_rst_zero_carry", {30'b0, z8, c8}, 32'd0);
    chk("mid_rst_in_ready", {31'b0, ir8}, 32'd1);
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    repeat (12) @(negedge CLK);
    chk("post_rst_in_ready", {31'b0, ir8}, 32'd1);

    // WIDTH=16
    issue(1, 3'b100, 16'hFFFF, 16'h0001, 16'h0000, 1, 1, 1, 1);
    issue(1, 3'b010, 16'h0100, 16'h0100, 16'h0000, 1, 1, 17, 1);
    issue(1, 3'b010, 16'h00FF, 16'h0101, 16'hFFFF, 0, 0, 17, 1);
    issue(1, 3'b101, 16'h8001, 16'd20,   16'h0000, 1, 1, 17, 1);
    issue(1, 3'b110, 16'h8001, 16'd15,   16'h0001, 0, 0, 16, 1);

    repeat (30) @(posedge CLK);
    chk("q8_drained", q8.size(), 32'd0);
    chk("q16_drained", q16.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
